// File: rtl/echo_fifo_n.sv
// Echo queue: stores {payload, repeat count} entries and replays each payload n times (n=0 acts as 1).
// Optional statistics counters req_count/beat_count are enabled with ECHO_FIFO_N_STATS_EN.
module echo_fifo_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RBITS = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     echoReq__ENA,
  input  logic [WIDTH-1:0]         echoReq_v,
  input  logic [RBITS-1:0]         echoReq_n,
  output logic                     echoReq__RDY,
  input  logic                     respond_rule__ENA,
  output logic                     respond_rule__RDY,
  output logic                     ind_echo__ENA,
  output logic [WIDTH-1:0]         ind_echo_v,
  output logic                     ind_echo_last,
  input  logic                     ind_echo__RDY,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef ECHO_FIFO_N_STATS_EN
  ,
  output logic [31:0]              req_count,
  output logic [31:0]              beat_count
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_v [DEPTH];
  logic [RBITS-1:0] mem_n [DEPTH];

  logic [AW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [RBITS-1:0] beat;
  logic [RBITS-1:0] head_n, eff_m1;
  logic             enq, fire, last, deq;

  assign echoReq__RDY      = (count < CNT_W'(DEPTH));
  assign respond_rule__RDY = (count != '0) & ind_echo__RDY;
  assign enq               = echoReq__ENA & echoReq__RDY;
  assign fire              = respond_rule__ENA & respond_rule__RDY;

  assign head_n = mem_n[rptr];
  // A zero repeat count still produces a single beat.
  assign eff_m1 = (head_n == '0) ? '0 : head_n - RBITS'(1);
  assign last   = (beat == eff_m1);
  assign deq    = fire & last;

  assign ind_echo__ENA  = fire;
  assign ind_echo_v     = mem_v[rptr];
  assign ind_echo_last  = last;
  assign occupancy      = count;

  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_v[wptr] <= echoReq_v;
      mem_n[wptr] <= echoReq_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      beat  <= '0;
    end else begin
      if (enq) wptr <= wptr + AW'(1);
      if (deq) rptr <= rptr + AW'(1);
      if (fire) beat <= last ? '0 : beat + RBITS'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ECHO_FIFO_N_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      req_count  <= '0;
      beat_count <= '0;
    end else begin
      if (enq)  req_count  <= req_count + 32'd1;
      if (fire) beat_count <= beat_count + 32'd1;
    end
  end
`endif

endmodule
